// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: opcodes, ALU operation codes
// (the alu_full fromContr field) and controller states.
package alu_issue_ctrl_pkg;

   typedef enum logic [3:0] {
      OPC_RTYPE = 4'd0,
      OPC_ADDI  = 4'd1,
      OPC_ANDI  = 4'd2,
      OPC_ORI   = 4'd3,
      OPC_SLTI  = 4'd4,
      OPC_LW    = 4'd5,
      OPC_SW    = 4'd6,
      OPC_LI    = 4'd7,
      OPC_BEQ   = 4'd8,
      OPC_BNE   = 4'd9,
      OPC_J     = 4'd10,
      OPC_JAL   = 4'd11
   } opcode_e;

   typedef enum logic [2:0] {
      ALUOP_RTYPE = 3'b000,
      ALUOP_OR    = 3'b001,
      ALUOP_ADD   = 3'b010,
      ALUOP_LI    = 3'b011,
      ALUOP_SUB   = 3'b100,
      ALUOP_JUMP  = 3'b101,
      ALUOP_AND   = 3'b110,
      ALUOP_SLT   = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_BADOP,
      ST_DONE
   } state_e;

endpackage

// File: rtl/alu_issue_ctrl_op_decode.sv
// Combinational opcode decoder: ALU operation code, R-type flag and the
// branch/jump/illegal qualifiers used by the issue controller.
module alu_op_decode
   import alu_issue_ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   output logic [2:0] alu_op,
   output logic       rtype,
   output logic       is_beq,
   output logic       is_bne,
   output logic       is_jump,
   output logic       illegal
);

   // opcode table lookup; anything outside the table is flagged illegal
   always_comb begin
      alu_op  = ALUOP_RTYPE;
      rtype   = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_jump = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            alu_op = ALUOP_RTYPE;
            rtype  = 1'b1;
         end
         OPC_ORI:   alu_op = ALUOP_OR;
         OPC_ADDI,
         OPC_LW,
         OPC_SW:    alu_op = ALUOP_ADD;
         OPC_LI:    alu_op = ALUOP_LI;
         OPC_BEQ: begin
            alu_op = ALUOP_SUB;
            is_beq = 1'b1;
         end
         OPC_BNE: begin
            alu_op = ALUOP_SUB;
            is_bne = 1'b1;
         end
         OPC_J,
         OPC_JAL: begin
            alu_op  = ALUOP_JUMP;
            is_jump = 1'b1;
         end
         OPC_ANDI:  alu_op = ALUOP_AND;
         OPC_SLTI:  alu_op = ALUOP_SLT;
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one decoded instruction, drives alu_full with
// registered stable inputs for EXEC_CYCLES, captures result/zero and holds a
// result record until downstream takes it.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_opcode,
   input  logic [5:0]       in_func,
   input  logic [3:0]       in_shamt,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [5:0]       alu_func,
   output logic [3:0]       alu_shamt,
   output logic             alu_rtype,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_branch_taken,
   output logic             out_jump,
   output logic             out_illegal
);

   localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          last_exec;
   logic          accept;
   logic          capture;
   logic          post_illegal;

   logic [2:0]    dec_op;
   logic          dec_rtype, dec_beq, dec_bne, dec_jump, dec_illegal;
   logic          pend_beq, pend_bne, pend_jump;

   alu_op_decode u_dec (
      .opcode  (in_opcode),
      .alu_op  (dec_op),
      .rtype   (dec_rtype),
      .is_beq  (dec_beq),
      .is_bne  (dec_bne),
      .is_jump (dec_jump),
      .illegal (dec_illegal)
   );

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // next-state, handshake outputs and datapath strobes
   // Illegal opcodes pass through ST_BADOP for one edge so the illegal record
   // appears with the same one-edge latency as a single-cycle execution.
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      capture      = 1'b0;
      post_illegal = 1'b0;
      last_exec    = (cnt_q == CNT_LAST);
      in_ready     = (state_q == ST_IDLE);
      out_valid    = (state_q == ST_DONE);
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (dec_illegal) begin
                  state_d = ST_BADOP;
               end else begin
                  accept  = 1'b1;
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (last_exec) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_BADOP: begin
            post_illegal = 1'b1;
            state_d      = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // EXEC cycle counter, cleared whenever not executing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (state_q == ST_EXEC && !last_exec) begin
         cnt_q <= cnt_q + CW'(1);
      end else begin
         cnt_q <= '0;
      end
   end

   // ALU drive registers, loaded only when a legal instruction is accepted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_func  <= '0;
         alu_shamt <= '0;
         alu_rtype <= 1'b0;
         alu_op    <= '0;
         pend_beq  <= 1'b0;
         pend_bne  <= 1'b0;
         pend_jump <= 1'b0;
      end else if (accept) begin
         alu_a     <= in_a;
         alu_b     <= in_b;
         alu_func  <= dec_rtype ? in_func  : '0;
         alu_shamt <= dec_rtype ? in_shamt : '0;
         alu_rtype <= dec_rtype;
         alu_op    <= dec_op;
         pend_beq  <= dec_beq;
         pend_bne  <= dec_bne;
         pend_jump <= dec_jump;
      end
   end

   // result record capture: ALU outputs at the last EXEC edge, or the illegal record
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_result       <= '0;
         out_zero         <= 1'b0;
         out_branch_taken <= 1'b0;
         out_jump         <= 1'b0;
         out_illegal      <= 1'b0;
      end else if (capture) begin
         out_result       <= alu_result;
         out_zero         <= alu_zero;
         out_branch_taken <= (pend_beq & alu_zero) | (pend_bne & ~alu_zero);
         out_jump         <= pend_jump;
         out_illegal      <= 1'b0;
      end else if (post_illegal) begin
         out_result       <= '0;
         out_zero         <= 1'b0;
         out_branch_taken <= 1'b0;
         out_jump         <= 1'b0;
         out_illegal      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural alu_full responder.
module tb_alu_issue_ctrl;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [3:0]   in_opcode;
   logic [5:0]   in_func;
   logic [3:0]   in_shamt;
   logic [W-1:0] in_a, in_b;

   // instance with EXEC_CYCLES=1
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] alu_a, alu_b, alu_result, out_result;
   logic [5:0]   alu_func;
   logic [3:0]   alu_shamt;
   logic [2:0]   alu_op;
   logic         alu_rtype, alu_zero, out_zero, out_branch_taken, out_jump, out_illegal;

   // instance with EXEC_CYCLES=3
   logic         in_valid3, in_ready3, out_valid3, out_ready3;
   logic [W-1:0] alu_a3, alu_b3, alu_result3, out_result3;
   logic [5:0]   alu_func3;
   logic [3:0]   alu_shamt3;
   logic [2:0]   alu_op3;
   logic         alu_rtype3, alu_zero3, out_zero3, out_branch_taken3, out_jump3, out_illegal3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // alu_full behaviour: fromContr selects the operation, R-type uses func
   function automatic logic [W:0] alu_fn(input logic [2:0] op, input logic [5:0] func,
                                         input logic [3:0] shamt, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic [W-1:0] r;
      r = '0;
      case (op)
         3'b000: case (func)
            6'b100000: r = a + b;
            6'b100010: r = a - b;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b101010: r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            6'b000000: r = b << shamt;
            default:   r = '0;
         endcase
         3'b001:  r = a | b;
         3'b010:  r = a + b;
         3'b011:  r = b;
         3'b100:  r = a - b;
         3'b101:  r = '0;
         3'b110:  r = a & b;
         default: r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      endcase
      return {(r == '0), r};
   endfunction

   assign {alu_zero,  alu_result}  = alu_fn(alu_op,  alu_func,  alu_shamt,  alu_a,  alu_b);
   assign {alu_zero3, alu_result3} = alu_fn(alu_op3, alu_func3, alu_shamt3, alu_a3, alu_b3);

   alu_issue_ctrl #(.WIDTH(W), .EXEC_CYCLES(1)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_func(in_func), .in_shamt(in_shamt),
      .in_a(in_a), .in_b(in_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_shamt(alu_shamt),
      .alu_rtype(alu_rtype), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero),
      .out_branch_taken(out_branch_taken), .out_jump(out_jump), .out_illegal(out_illegal)
   );

   alu_issue_ctrl #(.WIDTH(W), .EXEC_CYCLES(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid3), .in_ready(in_ready3),
      .in_opcode(in_opcode), .in_func(in_func), .in_shamt(in_shamt),
      .in_a(in_a), .in_b(in_b),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_func(alu_func3), .alu_shamt(alu_shamt3),
      .alu_rtype(alu_rtype3), .alu_op(alu_op3),
      .alu_result(alu_result3), .alu_zero(alu_zero3),
      .out_valid(out_valid3), .out_ready(out_ready3),
      .out_result(out_result3), .out_zero(out_zero3),
      .out_branch_taken(out_branch_taken3), .out_jump(out_jump3), .out_illegal(out_illegal3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // present one instruction for exactly one accepting edge; returns at edge+1ns
   task automatic issue(input logic to3, input logic [3:0] op, input logic [5:0] func,
                        input logic [3:0] shamt, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      in_opcode = op; in_func = func; in_shamt = shamt; in_a = a; in_b = b;
      if (to3) in_valid3 = 1'b1;
      else     in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_valid3 = 1'b0;
   endtask

   // count edges after acceptance until out_valid, bounded
   task automatic wait_valid(input string tag, input int exp_lat, input logic to3);
      int lat = 0;
      while (((to3 ? out_valid3 : out_valid) == 1'b0) && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk(tag, lat, exp_lat);
   endtask

   task automatic take(input logic to3);
      @(negedge clk);
      if (to3) out_ready3 = 1'b1;
      else     out_ready  = 1'b1;
      @(posedge clk);
      #1;
      out_ready  = 1'b0;
      out_ready3 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      reset_n = 1'b0;
      in_valid = 1'b0; in_valid3 = 1'b0; out_ready = 1'b0; out_ready3 = 1'b0;
      in_opcode = '0; in_func = '0; in_shamt = '0; in_a = '0; in_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_op",    alu_op,    0);
      chk("rst_alu_a",     alu_a,     0);
      chk("rst_result",    out_result, 0);
      chk("rst_in_ready3", in_ready3, 1);
      @(negedge clk);
      reset_n = 1'b1;

      // ADDI
      issue(0, 4'd1, 6'h00, 4'h0, 16'h5BF3, 16'h0011);
      chk("addi_alu_op",    alu_op,    3'b010);
      chk("addi_alu_rtype", alu_rtype, 0);
      chk("addi_alu_a",     alu_a,     16'h5BF3);
      chk("addi_in_ready",  in_ready,  0);
      wait_valid("addi_latency", 1, 0);
      chk("addi_result",    out_result, 16'h5C04);
      chk("addi_zero",      out_zero,   0);
      chk("addi_branch",    out_branch_taken, 0);
      chk("addi_illegal",   out_illegal, 0);
      take(0);
      chk("addi_release",   in_ready, 1);

      // RTYPE subtract
      issue(0, 4'd0, 6'b100010, 4'h3, 16'hFFFF, 16'hFFFF);
      chk("rt_alu_rtype", alu_rtype, 1);
      chk("rt_alu_func",  alu_func,  6'b100010);
      chk("rt_alu_shamt", alu_shamt, 4'h3);
      chk("rt_alu_op",    alu_op,    3'b000);
      wait_valid("rt_latency", 1, 0);
      chk("rt_result", out_result, 16'h0000);
      chk("rt_zero",   out_zero,   1);
      chk("rt_branch", out_branch_taken, 0);
      take(0);

      // BEQ taken; func/shamt must be forced to zero
      issue(0, 4'd8, 6'h3F, 4'hF, 16'hFFFF, 16'hFFFF);
      chk("beq_alu_op",    alu_op,    3'b100);
      chk("beq_alu_func",  alu_func,  6'h00);
      chk("beq_alu_shamt", alu_shamt, 4'h0);
      wait_valid("beq_latency", 1, 0);
      chk("beq_branch", out_branch_taken, 1);
      chk("beq_zero",   out_zero, 1);
      take(0);

      // BNE taken
      issue(0, 4'd9, 6'h00, 4'h0, 16'hAF23, 16'h0022);
      wait_valid("bne_latency", 1, 0);
      chk("bne_result", out_result, 16'hAF01);
      chk("bne_zero",   out_zero, 0);
      chk("bne_branch", out_branch_taken, 1);
      take(0);

      // ORI then back-pressure with a competing instruction waiting
      issue(0, 4'd3, 6'h00, 4'h0, 16'h00F0, 16'h0F0F);
      chk("ori_alu_op", alu_op, 3'b001);
      wait_valid("ori_latency", 1, 0);
      @(negedge clk);
      in_opcode = 4'd2; in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_result",    out_result, 16'h0FFF);
         chk("bp_in_ready",  in_ready, 0);
         chk("bp_alu_op",    alu_op, 3'b001);
      end
      @(negedge clk);
      in_valid = 1'b0;
      take(0);
      chk("bp_idle",      in_ready, 1);
      chk("bp_no_accept", alu_a, 16'h00F0);
      @(posedge clk);
      #1;
      chk("bp_no_record", out_valid, 0);

      // illegal opcode: ALU drive left from the ORI
      issue(0, 4'hF, 6'h00, 4'h0, 16'h1234, 16'h5678);
      chk("ill_alu_a",  alu_a,  16'h00F0);
      chk("ill_alu_op", alu_op, 3'b001);
      wait_valid("ill_latency", 1, 0);
      chk("ill_flag",   out_illegal, 1);
      chk("ill_result", out_result, 16'h0000);
      chk("ill_zero",   out_zero, 0);
      chk("ill_branch", out_branch_taken, 0);
      chk("ill_jump",   out_jump, 0);
      chk("ill_alu_b",  alu_b, 16'h0F0F);
      take(0);

      // J
      issue(0, 4'd10, 6'h00, 4'h0, 16'h1111, 16'h2222);
      chk("j_alu_op", alu_op, 3'b101);
      wait_valid("j_latency", 1, 0);
      chk("j_jump",    out_jump, 1);
      chk("j_branch",  out_branch_taken, 0);
      chk("j_illegal", out_illegal, 0);
      take(0);

      // EXEC_CYCLES=3 instance: full transaction
      issue(1, 4'd1, 6'h00, 4'h0, 16'h5BF3, 16'h0011);
      chk("x3_alu_op", alu_op3, 3'b010);
      wait_valid("x3_latency", 3, 1);
      chk("x3_result", out_result3, 16'h5C04);
      take(1);

      // reset mid-EXEC discards the instruction
      issue(1, 4'd1, 6'h00, 4'h0, 16'h0001, 16'h0001);
      @(posedge clk);
      #1;
      chk("rx_mid_valid", out_valid3, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rx_in_ready",  in_ready3, 1);
      chk("rx_out_valid", out_valid3, 0);
      chk("rx_alu_op",    alu_op3, 0);
      chk("rx_alu_a",     alu_a3, 0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (out_valid3) seen++;
      end
      chk("rx_never_valid", seen, 0);
      chk("rx_idle", in_ready3, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
